// File: rtl/onchip_sram_pipelined.sv
// Single-port Avalon-MM on-chip SRAM with a pipelined read path, waitrequest
// flow control and a hardware zero-fill sequencer.
module onchip_sram_pipelined #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    chipselect_i,
   input  logic                    read_i,
   input  logic                    write_i,
   input  logic [ADDR_WIDTH-1:0]   address_i,
   input  logic [DATA_WIDTH/8-1:0] byteenable_i,
   input  logic [DATA_WIDTH-1:0]   writedata_i,
   input  logic                    clken_i,
   input  logic                    clear_req_i,
   output logic [DATA_WIDTH-1:0]   readdata_o,
   output logic                    readdatavalid_o,
   output logic                    waitrequest_o,
   output logic                    busy_o
);

   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;

   typedef enum logic {CLEAR, READY} state_e;

   state_e                                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]                    clrCnt_q, clrCnt_d;
   logic [DATA_WIDTH-1:0]                    mem [DEPTH];
   logic [READ_LATENCY-1:0]                  rdValid_q;
   logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  rdData_q;
   logic                                     cmdAccept, writeAccept, readAccept;
   logic                                     ramWe;
   logic [ADDR_WIDTH-1:0]                    ramAddr;
   logic [DATA_WIDTH-1:0]                    ramWdata, wrMerged;

   // Held off while in reset too, so the bus sees no acceptance before the FSM is valid.
   assign waitrequest_o = ~reset_n_i | (state_q == CLEAR) | ~clken_i;
   assign busy_o        = (state_q == CLEAR);
   assign cmdAccept     = chipselect_i & ~waitrequest_o;
   assign writeAccept   = cmdAccept & write_i;
   assign readAccept    = cmdAccept & read_i & ~write_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         clrCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         clrCnt_q <= clrCnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      if (clken_i) begin
         case (state_q)
            CLEAR: begin
               if (&clrCnt_q) begin
                  state_d  = READY;
                  clrCnt_d = '0;
               end else begin
                  clrCnt_d = clrCnt_q + 1'b1;
               end
            end
            READY: begin
               if (clear_req_i) state_d = CLEAR;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Lane merge is done on the full word so the RAM sees one write per cycle.
   always_comb begin
      wrMerged = mem[address_i];
      for (int i = 0; i < NBYTES; i++) begin
         if (byteenable_i[i]) wrMerged[8*i +: 8] = writedata_i[8*i +: 8];
      end
   end

   always_comb begin
      ramWe    = 1'b0;
      ramAddr  = address_i;
      ramWdata = wrMerged;
      if (clken_i && state_q == CLEAR) begin
         ramWe    = 1'b1;
         ramAddr  = clrCnt_q;
         ramWdata = '0;
      end else if (writeAccept) begin
         ramWe = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
   end

   // Data stages load only behind a valid so readdata holds between pulses.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rdValid_q <= '0;
         rdData_q  <= '0;
      end else if (clken_i) begin
         rdValid_q[0] <= readAccept;
         if (readAccept) rdData_q[0] <= mem[address_i];
         for (int i = 1; i < READ_LATENCY; i++) begin
            rdValid_q[i] <= rdValid_q[i-1];
            if (rdValid_q[i-1]) rdData_q[i] <= rdData_q[i-1];
         end
      end
   end

   assign readdatavalid_o = rdValid_q[READ_LATENCY-1] & clken_i;
   assign readdata_o      = rdData_q[READ_LATENCY-1];

endmodule

// File: tb/tb_onchip_sram_pipelined.sv
// Directed bench driving a 1-cycle and a 2-cycle latency SRAM in lockstep,
// with a per-instance queue of expected read data and arrival cycles.
module tb_onchip_sram_pipelined;

   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      int          due;
   } expect_t;

   logic        clk = 1'b0;
   logic        resetN, chipselect, rd, wr, clken, clearReq;
   logic [3:0]  address, byteenable;
   logic [31:0] writedata;
   logic [31:0] rdataA, rdataB;
   logic        rvalidA, rvalidB, waitA, waitB, busyA, busyB;

   expect_t     q1[$];
   expect_t     q2[$];
   logic [31:0] model [DEPTH];
   int          cyc = 0;
   int          checks = 0;
   int          passCount = 0;
   int          failCount = 0;

   onchip_sram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dutA (
      .clk_i(clk), .reset_n_i(resetN), .chipselect_i(chipselect), .read_i(rd), .write_i(wr),
      .address_i(address), .byteenable_i(byteenable), .writedata_i(writedata), .clken_i(clken),
      .clear_req_i(clearReq), .readdata_o(rdataA), .readdatavalid_o(rvalidA),
      .waitrequest_o(waitA), .busy_o(busyA));

   onchip_sram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dutB (
      .clk_i(clk), .reset_n_i(resetN), .chipselect_i(chipselect), .read_i(rd), .write_i(wr),
      .address_i(address), .byteenable_i(byteenable), .writedata_i(writedata), .clken_i(clken),
      .clear_req_i(clearReq), .readdata_o(rdataB), .readdatavalid_o(rvalidB),
      .waitrequest_o(waitB), .busy_o(busyB));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one command for one clock; reads are queued with their due cycle.
   task automatic applyStimulus(input logic rdIn, input logic wrIn, input logic [3:0] addr,
                                input logic [3:0] be, input logic [31:0] data,
                                input logic clr, input int extra);
      expect_t e;
      chipselect = rdIn | wrIn;
      rd         = rdIn;
      wr         = wrIn;
      address    = addr;
      byteenable = be;
      writedata  = data;
      clearReq   = clr;
      if (wrIn) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
         end
      end else if (rdIn) begin
         e.data = model[addr];
         e.due  = cyc + 1 + extra;
         q1.push_back(e);
         e.due  = cyc + 2 + extra;
         q2.push_back(e);
      end
      @(posedge clk); #1;
      chipselect = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;
      clearReq   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic checkClearRun(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("busy/wait during clear", {28'd0, busyA, busyB, waitA, waitB}, 32'hF);
      end
      @(negedge clk);
      checkOutput("ready after clear", {28'd0, busyA, busyB, waitA, waitB}, 32'h0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : monitor
      expect_t e;
      if (rvalidA) begin
         if (q1.size() == 0) checkOutput("rl1 unexpected readdatavalid", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            checkOutput("rl1 readdata", rdataA, e.data);
            checkOutput("rl1 latency cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (rvalidB) begin
         if (q2.size() == 0) checkOutput("rl2 unexpected readdatavalid", 32'd1, 32'd0);
         else begin
            e = q2.pop_front();
            checkOutput("rl2 readdata", rdataB, e.data);
            checkOutput("rl2 latency cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, observed hang expected completion");
      $fatal(1);
   end

   initial begin
      resetN = 1'b0; clken = 1'b1; chipselect = 1'b0; rd = 1'b0; wr = 1'b0;
      clearReq = 1'b0; address = '0; byteenable = '0; writedata = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

      // reset values and fill on reset release
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset readdata rl1", rdataA, 32'h0);
      checkOutput("reset readdata rl2", rdataB, 32'h0);
      checkOutput("reset valids", {30'd0, rvalidA, rvalidB}, 32'h0);
      checkOutput("reset wait/busy", {28'd0, waitA, waitB, busyA, busyB}, 32'hF);
      @(posedge clk); #1;
      resetN = 1'b1;
      checkClearRun(DEPTH);
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'(a), 4'h0, 32'h0, 1'b0, 0);

      // byte enables, including an all-zero enable
      applyStimulus(1'b0, 1'b1, 4'd5, 4'b0101, 32'hDEADBEEF, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd5, 4'h0, 32'h0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 4'd6, 4'b0000, 32'hFFFFFFFF, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd6, 4'h0, 32'h0, 1'b0, 0);
      idle(3);

      // streaming reads and readdata hold
      applyStimulus(1'b0, 1'b1, 4'd0, 4'hF, 32'h11, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 4'd1, 4'hF, 32'h22, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 4'd2, 4'hF, 32'h33, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 4'd3, 4'hF, 32'h44, 1'b0, 0);
      for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 4'(a), 4'h0, 32'h0, 1'b0, 0);
      idle(4);
      checkOutput("readdata hold rl1", rdataA, 32'h44);
      checkOutput("readdata hold rl2", rdataB, 32'h44);

      // read+write together: write lands, read dropped; read-after-write
      applyStimulus(1'b1, 1'b1, 4'd7, 4'hF, 32'h77, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 4'd8, 4'hF, 32'h88, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd8, 4'h0, 32'h0, 1'b0, 0);
      idle(3);

      // three-cycle clken stall with a read in flight
      applyStimulus(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0, 3);
      clken = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("wait during stall", {30'd0, waitA, waitB}, 32'h3);
         @(posedge clk); #1;
      end
      clken = 1'b1;
      idle(3);

      // clear request with two reads in flight, stall and repeated request inside CLEAR
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 1'b1, 4'(a), 4'hF, 32'hFFFFFFFF, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 1'b1, 0);
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         checkOutput("busy/wait in requested clear", {28'd0, busyA, busyB, waitA, waitB}, 32'hF);
         clearReq = (i == 3);
         clken    = !(i >= 5 && i <= 7);
      end
      @(negedge clk);
      checkOutput("ready after requested clear", {28'd0, busyA, busyB, waitA, waitB}, 32'h0);
      @(posedge clk); #1;
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'(a), 4'h0, 32'h0, 1'b0, 0);
      idle(4);

      // reset with a read in flight
      applyStimulus(1'b0, 1'b1, 4'd1, 4'hF, 32'hA5A5A5A5, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd1, 4'h0, 32'h0, 1'b0, 0);
      resetN = 1'b0;
      q1.delete();
      q2.delete();
      #1;
      checkOutput("reset kills valid", {30'd0, rvalidA, rvalidB}, 32'h0);
      checkOutput("reset wait", {30'd0, waitA, waitB}, 32'h3);
      checkOutput("reset clears readdata", rdataA, 32'h0);
      @(posedge clk); #1;
      resetN = 1'b1;
      model[1] = 32'h0;
      checkClearRun(DEPTH);

      // reset mid-clear at count 7 restarts the fill from address 0
      applyStimulus(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 0);
      idle(7);
      checkOutput("busy before mid-clear reset", {30'd0, busyA, busyB}, 32'h3);
      resetN = 1'b0;
      #1;
      checkOutput("mid-clear reset valid", {30'd0, rvalidA, rvalidB}, 32'h0);
      checkOutput("mid-clear reset wait/busy", {28'd0, waitA, waitB, busyA, busyB}, 32'hF);
      @(posedge clk); #1;
      resetN = 1'b1;
      checkClearRun(DEPTH);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 4'd15, 4'h0, 32'h0, 1'b0, 0);
      idle(4);

      checkOutput("rl1 queue drained", 32'(q1.size()), 32'd0);
      checkOutput("rl2 queue drained", 32'(q2.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checks);
      $finish;
   end

endmodule
